// File: rtl/program_loader_pkg.sv
// Shared constants and types for the boot program loader: FSM encoding and byte-lane geometry.
package program_loader_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = LANES * BYTE_W;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them
// to consecutive word addresses while holding the core in reset until the load completes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   byte_valid,
  input  logic [BYTE_W-1:0]      byte_data,
  output logic                   byte_ready,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_W-1:0]      mem_data,
  input  logic                   mem_ready,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done
);

  state_t                  state, state_n;
  logic [LANE_IDX_W-1:0]   idx, idx_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic [COUNT_WIDTH-1:0]  remaining, remaining_n;
  logic [WORD_W-1:0]       word, word_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_n;
  logic [WORD_W-1:0]       mem_data_n;
  logic                    byte_ready_n, mem_write_n, cpu_hold_n, busy_n, done_n;
  logic                    accept_c;
  logic                    write_fire_c;

  assign accept_c     = byte_valid && byte_ready;
  assign write_fire_c = mem_write && mem_ready;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    addr_n      = addr;
    remaining_n = remaining;
    word_n      = word;
    mem_addr_n  = mem_addr;
    mem_data_n  = mem_data;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          addr_n      = base_addr & ~ADDR_WIDTH'(3);
          remaining_n = word_count;
          idx_n       = '0;
          word_n      = '0;
          state_n     = (word_count == '0) ? ST_DONE : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (accept_c) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            if (idx == LANE_IDX_W'(l)) word_n[l*BYTE_W +: BYTE_W] = byte_data;
          end
          if (idx == LANE_IDX_W'(LANES - 1)) begin
            mem_data_n = word_n;
            mem_addr_n = addr;
            idx_n      = '0;
            word_n     = '0;
            state_n    = ST_WRITE;
          end else begin
            idx_n = idx + LANE_IDX_W'(1);
          end
        end
      end

      ST_WRITE: begin
        // Address and data are held until the memory takes the word
        if (write_fire_c) begin
          addr_n      = addr + ADDR_WIDTH'(4);
          remaining_n = remaining - COUNT_WIDTH'(1);
          state_n     = (remaining == COUNT_WIDTH'(1)) ? ST_DONE : ST_COLLECT;
        end
      end

      ST_DONE: begin
        state_n = ST_DONE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    byte_ready_n = (state_n == ST_COLLECT);
    mem_write_n  = (state_n == ST_WRITE);
    busy_n       = (state_n == ST_COLLECT) || (state_n == ST_WRITE);
    done_n       = (state_n == ST_DONE);
    cpu_hold_n   = (state_n != ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      addr       <= '0;
      remaining  <= '0;
      word       <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      byte_ready <= 1'b0;
      mem_write  <= 1'b0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      addr       <= addr_n;
      remaining  <= remaining_n;
      word       <= word_n;
      mem_addr   <= mem_addr_n;
      mem_data   <= mem_data_n;
      byte_ready <= byte_ready_n;
      mem_write  <= mem_write_n;
      cpu_hold   <= cpu_hold_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of memory byte address.
REQ-002 Parameter COUNT_WIDTH, default 16, width of word-count field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse beginning a load; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_WIDTH  first memory byte address, captured on accepted start.
REQ-007 word_count  input  COUNT_WIDTH  number of 32-bit words to load, captured on accepted start.
REQ-008 byte_valid  input  1  byte stream data valid.
REQ-009 byte_data  input  8  byte stream payload.
REQ-010 byte_ready  output  1  loader accepts byte this cycle.
REQ-011 mem_write  output  1  memory write request.
REQ-012 mem_addr  output  ADDR_WIDTH  word-aligned write address.
REQ-013 mem_data  output  32  write word.
REQ-014 mem_ready  input  1  memory accepts the write this cycle.
REQ-015 cpu_hold  output  1  active-high hold driven to core reset; released only when load completes.
REQ-016 busy  output  1  high in COLLECT or WRITE.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 FSM states IDLE, COLLECT, WRITE, DONE.
REQ-019 IDLE: start=1 captures base_addr (low 2 bits forced to 0) and word_count; next COLLECT, or DONE if word_count=0.
REQ-020 COLLECT: byte_ready=1; byte accepted when byte_valid&&byte_ready; bytes packed little-endian (1st byte -> [7:0], 4th -> [31:24]).
REQ-021 4th accepted byte moves to WRITE next cycle with mem_data = assembled word, mem_addr = current address.
REQ-022 WRITE: byte_ready=0; mem_write=1 and mem_addr/mem_data held stable until mem_ready=1.
REQ-023 On mem_write&&mem_ready: address += 4 (mod 2^ADDR_WIDTH, wraps silently), remaining count -= 1; next DONE if remaining becomes 0, else COLLECT.
REQ-024 mem_ready already high on first WRITE cycle: write completes in that cycle (minimum 1 cycle per write).
REQ-025 Minimum throughput: 4 byte cycles + 1 write cycle per word.
REQ-026 byte_valid with byte_ready=0 is ignored; no byte dropped or duplicated.
REQ-027 start asserted outside IDLE is ignored.
REQ-028 DONE: cpu_hold=0, done=1; stays in DONE until reset (one load per reset).
REQ-029 cpu_hold=1 in IDLE, COLLECT, WRITE.
REQ-030 mem_write=0 outside WRITE; byte_ready=0 outside COLLECT.

Reset
REQ-031 reset=0 asynchronously forces IDLE, byte index 0, address 0, count 0, assembled word 0.
REQ-032 Reset outputs: byte_ready=0, mem_write=0, mem_addr=0, mem_data=0, cpu_hold=1, busy=0, done=0.
REQ-033 Reset mid-COLLECT or mid-WRITE aborts the load; partial word discarded; no further mem_write.

Structure
REQ-034 FSM state encodings and byte-lane count (4) are constants in the shared parameters file.
REQ-035 Single module; no sub-module; byte assembler is a 32-bit shift/lane register inside.

Verification
REQ-036 start, base=0x100, count=2, bytes 13 05 00 00 93 05 10 00, mem_ready=1 -> writes 0x00000513@0x100, 0x00100593@0x104; done=1, cpu_hold=0.
REQ-037 count=1, mem_ready low 3 cycles in WRITE -> mem_write held 4 cycles, addr/data stable, byte_ready=0 throughout.
REQ-038 count=0 start -> DONE next cycle, no mem_write, cpu_hold=0.
REQ-039 base=0xFFFFFFFC, count=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-040 reset=0 after 2 bytes of first word -> immediate IDLE, cpu_hold=1, no mem_write; start after reset loads cleanly from byte 0.
REQ-041 byte_valid gaps between bytes and start pulse during COLLECT -> word assembled correctly, start ignored.
